bifrost_mmu: RTL and testbench

//  Bank mapper sitting directly upstream of the address decoder. Translates the
//  6502's 16-bit cpu_addr into the 19-bit physical addr that the decoder consumes.

---
 rtl/bifrost_pkg.sv | 32 +++
 rtl/mmu_unlock_fsm.sv | 61 ++++++
 rtl/bifrost_mmu.sv | 140 ++++++++++++++
 tb/tb_bifrost_mmu.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bifrost_pkg.sv
// bifrost_pkg: shared definitions for the bifrost bank mapper.
//   FRAME_W           physical frame width (addr[18:12])
//   *_DEFAULT         default register window base and unlock keys
//   REG_CTRL/KEY/STAT register offsets inside the 32-byte window
//   IO_PAGE           CPU page that is always mapped to its own frame
//   lock_state_t      states of the register-write unlock FSM
//   identity_frame()  frame number of the identity mapping for a page
package bifrost_pkg;

  localparam int FRAME_W = 7;

  localparam logic [15:0] BASE_DEFAULT  = 16'hDE00;
  localparam logic [7:0]  KEY_A_DEFAULT = 8'hA5;
  localparam logic [7:0]  KEY_B_DEFAULT = 8'h5A;

  localparam logic [4:0] REG_CTRL = 5'h10;
  localparam logic [4:0] REG_KEY  = 5'h11;
  localparam logic [4:0] REG_STAT = 5'h12;

  localparam logic [3:0] IO_PAGE = 4'hD;

  typedef enum logic [1:0] {
    LK_LOCKED   = 2'd0,
    LK_KEY1     = 2'd1,
    LK_UNLOCKED = 2'd2
  } lock_state_t;

  function automatic logic [FRAME_W-1:0] identity_frame(input logic [3:0] page);
    return {{(FRAME_W-4){1'b0}}, page};
  endfunction

endpackage

// File: rtl/mmu_unlock_fsm.sv
// mmu_unlock_fsm: two-byte unlock sequence guarding the mapper registers.
//   clock, reset  system clock, asynchronous active-high reset
//   key_wr        a write to the KEY register is happening this cycle
//   other_wr      a write to any other register of the window this cycle
//   key_data      byte written to KEY
//   unlocked      registered: table/CTRL writes are allowed
//   state         current lock state, exposed for observation
// Valid/ready: none; every input is a single-cycle strobe sampled at the edge.
module mmu_unlock_fsm
  import bifrost_pkg::*;
#(
  parameter logic [7:0] KEY_A = KEY_A_DEFAULT,
  parameter logic [7:0] KEY_B = KEY_B_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_wr,
  input  logic        other_wr,
  input  logic [7:0]  key_data,
  output logic        unlocked,
  output lock_state_t state
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= LK_LOCKED;
      unlocked <= 1'b0;
    end else begin
      case (state)
        LK_LOCKED: begin
          if (key_wr && key_data == KEY_A) begin
            state <= LK_KEY1;
          end
          unlocked <= 1'b0;
        end
        LK_KEY1: begin
          if (key_wr && key_data == KEY_B) begin
            state    <= LK_UNLOCKED;
            unlocked <= 1'b1;
          end else if (key_wr || other_wr) begin
            // A wrong key or any interleaved register write aborts the sequence.
            state    <= LK_LOCKED;
            unlocked <= 1'b0;
          end
        end
        LK_UNLOCKED: begin
          // Any KEY write relocks, whatever its value.
          if (key_wr) begin
            state    <= LK_LOCKED;
            unlocked <= 1'b0;
          end
        end
        default: begin
          state    <= LK_LOCKED;
          unlocked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/bifrost_mmu.sv
// bifrost_mmu: 6502 bank mapper in front of the address decoder.
//   clock, reset  system clock, asynchronous active-high reset
//   cpu_addr      CPU address bus
//   rw            CPU read(1)/write(0)
//   data_in       CPU write data
//   data_out      registered register read data
//   data_oe       high when data_out drives the bus
//   addr          19-bit physical address (zero latency from registered tables)
// The CPU fills a shadow table of 16 page frames through the register window
// and commits it to the active table in one edge. Writes need an unlock.
// Build option: define MMU_READBACK_EN to make the shadow table readable;
// without it only STAT is readable and the readback mux is not built.
// Valid/ready: none; a register access is one bus cycle, reads return data
// in the cycle after the address.
module bifrost_mmu
  import bifrost_pkg::*;
#(
  parameter logic [15:0] BASE  = BASE_DEFAULT,
  parameter logic [7:0]  KEY_A = KEY_A_DEFAULT,
  parameter logic [7:0]  KEY_B = KEY_B_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        rw,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic [18:0] addr
);

  logic [FRAME_W-1:0] shadow [16];
  logic [FRAME_W-1:0] active [16];
  logic               commit_done;

  logic        sel;
  logic        wr;
  logic        rd;
  logic [4:0]  offset;
  logic        key_wr;
  logic        other_wr;
  logic        tbl_wr;
  logic        unlocked;
  lock_state_t lock_state;
  logic [7:0]  stat;

  assign sel      = (cpu_addr[15:5] == BASE[15:5]);
  assign wr       = sel & ~rw;
  assign rd       = sel & rw;
  assign offset   = cpu_addr[4:0];
  assign key_wr   = wr & (offset == REG_KEY);
  assign other_wr = wr & (offset != REG_KEY);
  assign tbl_wr   = wr & (lock_state == LK_UNLOCKED);
  assign stat     = {6'b0, commit_done, unlocked};

  mmu_unlock_fsm #(
    .KEY_A (KEY_A),
    .KEY_B (KEY_B)
  ) u_unlock (
    .clock    (clock),
    .reset    (reset),
    .key_wr   (key_wr),
    .other_wr (other_wr),
    .key_data (data_in),
    .unlocked (unlocked),
    .state    (lock_state)
  );

  // Shadow/active tables and the sticky commit flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        shadow[i] <= identity_frame(4'(i));
        active[i] <= identity_frame(4'(i));
      end
      commit_done <= 1'b0;
    end else begin
      if (tbl_wr && !offset[4]) begin
        shadow[offset[3:0]] <= data_in[FRAME_W-1:0];
      end
      if (tbl_wr && offset == REG_CTRL) begin
        if (data_in[1]) begin
          for (int i = 0; i < 16; i++) begin
            shadow[i] <= identity_frame(4'(i));
          end
        end
        if (data_in[0]) begin
          // With both bits set the identity map is what gets committed.
          for (int i = 0; i < 16; i++) begin
            active[i] <= data_in[1] ? identity_frame(4'(i)) : shadow[i];
          end
          commit_done <= 1'b1;
        end
      end
      if (rd && offset == REG_STAT) begin
        commit_done <= 1'b0;
      end
    end
  end

`ifdef MMU_READBACK_EN
  logic [7:0] rd_mux;

  always_comb begin
    rd_mux = 8'h00;
    if (!offset[4]) begin
      rd_mux = {1'b0, shadow[offset[3:0]]};
    end else if (offset == REG_STAT) begin
      rd_mux = stat;
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out <= 8'h00;
      data_oe  <= 1'b0;
    end else if (rd) begin
`ifdef MMU_READBACK_EN
      data_out <= rd_mux;
      data_oe  <= 1'b1;
`else
      data_out <= (offset == REG_STAT) ? stat : 8'h00;
      data_oe  <= (offset == REG_STAT);
`endif
    end else begin
      data_out <= 8'h00;
      data_oe  <= 1'b0;
    end
  end

  // Translation: the I/O page bypasses the table so it can never be unmapped.
  logic [3:0]         page;
  logic [FRAME_W-1:0] frame;

  assign page  = cpu_addr[15:12];
  assign frame = (page == IO_PAGE) ? identity_frame(IO_PAGE) : active[page];
  assign addr  = {frame, cpu_addr[11:0]};

endmodule

// File: tb/tb_bifrost_mmu.sv
module tb_bifrost_mmu;

  localparam logic [15:0] IDLE = 16'h0000;
  localparam logic [15:0] WIN  = 16'hDE00;

  logic        clock;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        rw;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [18:0] addr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] exp_q[$];

  // Reference model: table contents and lock progress as plain integers.
  int m_shadow [16];
  int m_active [16];
  int m_lock;       // 0 locked, 1 first key seen, 2 unlocked
  bit m_done;

  bifrost_mmu dut (
    .clock    (clock),
    .reset    (reset),
    .cpu_addr (cpu_addr),
    .rw       (rw),
    .data_in  (data_in),
    .data_out (data_out),
    .data_oe  (data_oe),
    .addr     (addr)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_shadow[i] = i;
      m_active[i] = i;
    end
    m_lock = 0;
    m_done = 1'b0;
  endtask

  task automatic model_write(input int off, input int d);
    if (off == 17) begin
      case (m_lock)
        0:       m_lock = (d == 8'hA5) ? 1 : 0;
        1:       m_lock = (d == 8'h5A) ? 2 : 0;
        default: m_lock = 0;
      endcase
    end else if (m_lock == 1) begin
      m_lock = 0;
    end else if (m_lock == 2) begin
      if (off < 16) begin
        m_shadow[off] = d % 128;
      end else if (off == 16) begin
        if ((d / 2) % 2 == 1) begin
          for (int i = 0; i < 16; i++) m_shadow[i] = i;
        end
        if (d % 2 == 1) begin
          for (int i = 0; i < 16; i++) m_active[i] = m_shadow[i];
          m_done = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [8:0] model_read(input int off);
    int s;
    s = (m_done ? 2 : 0) + (m_lock == 2 ? 1 : 0);
`ifdef MMU_READBACK_EN
    if (off < 16) return {1'b1, 8'(m_shadow[off])};
    if (off == 18) return {1'b1, 8'(s)};
    return {1'b1, 8'h00};
`else
    if (off == 18) return {1'b1, 8'(s)};
    return 9'h000;
`endif
  endfunction

  function automatic logic [18:0] model_xlate(input logic [15:0] a);
    int pg;
    int fr;
    pg = int'(a[15:12]);
    fr = (pg == 13) ? 13 : m_active[pg];
    return 19'((fr * 4096) + int'(a[11:0]));
  endfunction

  function automatic bit in_window(input logic [15:0] a);
    return a[15:5] == WIN[15:5];
  endfunction

  // Driver tasks: each bus operation consumes exactly one clock edge.
  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a;
    rw       = 1'b0;
    data_in  = d;
    @(posedge clock);
    #1;
    if (in_window(a)) model_write(int'(a[4:0]), int'(d));
    check("wr_oe", 32'(data_oe), 32'd0);
    cpu_addr = IDLE;
    rw       = 1'b1;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] got);
    logic [8:0] e;
    cpu_addr = a;
    rw       = 1'b1;
    exp_q.push_back(in_window(a) ? model_read(int'(a[4:0])) : 9'h000);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check("rd_oe", 32'(data_oe), 32'(e[8]));
    check("rd_data", 32'(data_out), 32'(e[7:0]));
    if (in_window(a) && a[4:0] == 5'h12) m_done = 1'b0;
    got      = data_out;
    cpu_addr = IDLE;
  endtask

  task automatic check_xlate(input logic [15:0] a);
    cpu_addr = a;
    rw       = 1'b1;
    #1;
    check("xlate", 32'(addr), 32'(model_xlate(a)));
    cpu_addr = IDLE;
  endtask

  task automatic check_addr_lit(input string tag, input logic [15:0] a, input logic [18:0] e);
    cpu_addr = a;
    rw       = 1'b1;
    #1;
    check(tag, 32'(addr), 32'(e));
    cpu_addr = IDLE;
  endtask

  initial begin
    logic [7:0] got;
    int         op;
    logic [15:0] a;

    reset    = 1'b1;
    cpu_addr = IDLE;
    rw       = 1'b1;
    data_in  = 8'h00;
    model_reset();
    #2;
    check("rst_oe", 32'(data_oe), 32'd0);
    check("rst_dout", 32'(data_out), 32'd0);
    check_addr_lit("t1_8123", 16'h8123, 19'h08123);
    check_addr_lit("t1_fffc", 16'hFFFC, 19'h0FFFC);
    #8 reset = 1'b0;
    @(posedge clock);
    #1;

    // Locked: writes are ignored.
    bus_write(16'hDE08, 8'h42);
    bus_write(16'hDE10, 8'h01);
    bus_read(16'hDE08, got);
`ifdef MMU_READBACK_EN
    check("t2_rd08", 32'(got), 32'h08);
`endif
    check_addr_lit("t2_8000", 16'h8000, 19'h08000);

    // Unlock, map page 8 to frame $42, commit.
    bus_write(16'hDE11, 8'hA5);
    bus_write(16'hDE11, 8'h5A);
    bus_write(16'hDE08, 8'h42);
    bus_write(16'hDE10, 8'h01);
    check_addr_lit("t3_8abc", 16'h8ABC, 19'h42ABC);
    bus_read(16'hDE12, got);
    check("t3_stat1", 32'(got), 32'h03);
    bus_read(16'hDE12, got);
    check("t3_stat2", 32'(got), 32'h01);

    // The I/O page cannot be remapped.
    bus_write(16'hDE0D, 8'h7F);
    bus_write(16'hDE10, 8'h01);
    check_addr_lit("t4_d400", 16'hD400, 19'h0D400);

    // Broken sequence leaves the block locked.
    bus_write(16'hDE11, 8'h00);   // relock from unlocked
    bus_write(16'hDE11, 8'hA5);
    bus_write(16'hDE11, 8'h00);
    bus_write(16'hDE11, 8'h5A);
    bus_read(16'hDE12, got);
    check("t5_stat_b0", 32'(got[0]), 32'd0);
    bus_write(16'hDE03, 8'h55);
    bus_write(16'hDE10, 8'h01);
    check_addr_lit("t5_3456", 16'h3456, 19'h03456);

    // Identity-and-commit in one CTRL write.
    bus_write(16'hDE11, 8'hA5);
    bus_write(16'hDE11, 8'h5A);
    bus_write(16'hDE10, 8'h03);
    check_addr_lit("both_8abc", 16'h8ABC, 19'h08ABC);

    // Randomised traffic against the model.
    for (int n = 0; n < 500; n++) begin
      op = $urandom_range(0, 99);
      if (op < 30) begin
        bus_write(WIN | 16'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      end else if (op < 40) begin
        bus_write(WIN | 16'h10, 8'($urandom_range(0, 3)));
      end else if (op < 55) begin
        case ($urandom_range(0, 4))
          0, 1:    bus_write(WIN | 16'h11, 8'hA5);
          2, 3:    bus_write(WIN | 16'h11, 8'h5A);
          default: bus_write(WIN | 16'h11, 8'($urandom_range(0, 255)));
        endcase
      end else if (op < 65) begin
        bus_write(WIN | 16'h11, 8'hA5);
        bus_write(WIN | 16'h11, 8'h5A);
      end else if (op < 90) begin
        bus_read(WIN | 16'($urandom_range(0, 31)), got);
      end else begin
        a = 16'($urandom_range(0, 65535));
        if (in_window(a)) a = 16'h1234;
        bus_write(a, 8'($urandom_range(0, 255)));
      end
      check_xlate(16'($urandom_range(0, 65535)));
    end

    // Asynchronous reset mid-cycle while mapped and unlocked.
    bus_write(16'hDE11, 8'hA5);
    bus_write(16'hDE11, 8'h5A);
    bus_write(16'hDE08, 8'h42);
    bus_write(16'hDE10, 8'h01);
    check_addr_lit("t6_pre", 16'h8000, 19'h42000);
    bus_read(16'hDE12, got);
    check("t6_pre_oe", 32'(data_oe), 32'd1);
    cpu_addr = 16'h8000;
    #3 reset = 1'b1;
    #1;
    model_reset();
    check("t6_addr", 32'(addr), 32'h08000);
    check("t6_oe", 32'(data_oe), 32'd0);
    check("t6_dout", 32'(data_out), 32'd0);
    #2 reset = 1'b0;
    @(posedge clock);
    #1;
    bus_read(16'hDE12, got);
    check("t6_stat", 32'(got), 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
